// File: rtl/move_scheduler_if.sv
// Game-FSM side of the move scheduler: board (re)start request, move request
// and the per-move result. The game FSM is the master, the scheduler the slave.
interface move_scheduler_if;
  logic       start_game;
  logic       move_req;
  logic [6:0] move_addr;
  logic       player;
  logic       move_ack;
  logic       move_valid_o;
  logic [7:0] valid_mask_o;
  logic       timeout_o;
  logic       busy_o;

  modport master (
    output start_game, move_req, move_addr, player,
    input  move_ack, move_valid_o, valid_mask_o, timeout_o, busy_o
  );

  modport slave (
    input  start_game, move_req, move_addr, player,
    output move_ack, move_valid_o, valid_mask_o, timeout_o, busy_o
  );
endinterface

// File: rtl/move_scheduler.sv
// Top-level sequencer for the gameboard RAM and the move validator.
// Kicks the board initializer, then owns RAM port selection. Each move request
// runs the validator once per direction (8 passes) and collects a capture mask.
module move_scheduler #(
  parameter int ROW_STRIDE = 10,
  parameter int CELLS      = 100,
  parameter int TIMEOUT    = 255
) (
  input  logic             clock,
  input  logic             reset,
  move_scheduler_if.slave  game,
  output logic             init_start_o,
  input  logic             init_done_i,
  output logic [6:0]       v_addr_o,
  output logic             v_player_o,
  output logic [4:0]       v_step_o,
  output logic             v_ld_o,
  output logic             v_en_o,
  input  logic             v_dir_status_i,
  input  logic             v_done_i,
  input  logic [6:0]       i_addr,
  input  logic [1:0]       i_data,
  input  logic             i_wren,
  input  logic [6:0]       v_addr,
  input  logic [1:0]       v_data,
  input  logic             v_wren,
  output logic [6:0]       ram_addr,
  output logic [1:0]       ram_data,
  output logic             ram_wren
);

  localparam int              CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [6:0]      CELL_LIMIT = 7'(CELLS);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_MOVE, S_LOAD, S_RUN, S_NEXT, S_REPORT
  } state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_VAL} owner_t;

  state_t           state, state_next;
  owner_t           owner, owner_next;
  logic [2:0]       dir_idx;
  logic [CNT_W-1:0] cyc_cnt;
  logic [7:0]       mask;
  logic             timeout_q;
  logic [6:0]       addr_q;
  logic             player_q;
  logic             run_end;

  // Step for each direction in fixed order: +1, -1, +R, -R, +R+1, -R-1, +R-1, -R+1.
  function automatic logic [4:0] step_of(input logic [2:0] dir);
    logic [4:0] step;
    case (dir)
      3'd0:    step = 5'(1);
      3'd1:    step = 5'(-1);
      3'd2:    step = 5'(ROW_STRIDE);
      3'd3:    step = 5'(-ROW_STRIDE);
      3'd4:    step = 5'(ROW_STRIDE + 1);
      3'd5:    step = 5'(-ROW_STRIDE - 1);
      3'd6:    step = 5'(ROW_STRIDE - 1);
      default: step = 5'(-ROW_STRIDE + 1);
    endcase
    return step;
  endfunction

  // A pass ends when the validator finishes or the cycle budget runs out.
  assign run_end = v_done_i || (cyc_cnt == CNT_LAST);

  // State and RAM-owner registers; owner tracks the state being entered.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Next-state logic and the RAM owner implied by the next state.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    owner_next = OWN_NONE;
    case (state)
      S_IDLE:      if (game.start_game) state_next = S_INIT;
      S_INIT:      if (init_done_i) state_next = S_WAIT_MOVE;
      S_WAIT_MOVE: begin
        if (game.start_game)
          state_next = S_INIT;
        else if (game.move_req)
          state_next = (game.move_addr < CELL_LIMIT) ? S_LOAD : S_REPORT;
      end
      S_LOAD:      state_next = S_RUN;
      S_RUN:       if (run_end) state_next = S_NEXT;
      S_NEXT:      state_next = (dir_idx == 3'd7) ? S_REPORT : S_LOAD;
      S_REPORT:    state_next = S_WAIT_MOVE;
      default:     state_next = S_IDLE;
    endcase
    case (state_next)
      S_INIT:                           owner_next = OWN_INIT;
      S_LOAD, S_RUN, S_NEXT, S_REPORT:  owner_next = OWN_VAL;
      default:                          owner_next = OWN_NONE;
    endcase
  end

  // Per-move datapath: latched request, direction index, pass counter, result mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      player_q  <= 1'b0;
      mask      <= '0;
      timeout_q <= 1'b0;
      dir_idx   <= '0;
      cyc_cnt   <= '0;
    end else begin
      case (state)
        S_WAIT_MOVE: begin
          if (game.move_req && !game.start_game) begin
            addr_q    <= game.move_addr;
            player_q  <= game.player;
            mask      <= '0;
            timeout_q <= 1'b0;
            dir_idx   <= '0;
          end
        end
        S_LOAD: cyc_cnt <= '0;
        S_RUN: begin
          if (v_done_i) begin
            mask[dir_idx] <= v_dir_status_i;
          end else if (cyc_cnt == CNT_LAST) begin
            mask[dir_idx] <= 1'b0;
            timeout_q     <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        S_NEXT: if (dir_idx != 3'd7) dir_idx <= dir_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign init_start_o      = (state == S_INIT);
  assign v_ld_o            = (state == S_LOAD);
  assign v_en_o            = (state == S_RUN);
  assign v_step_o          = (state inside {S_LOAD, S_RUN, S_NEXT}) ? step_of(dir_idx) : 5'd0;
  assign v_addr_o          = addr_q;
  assign v_player_o        = player_q;
  assign game.move_ack     = (state == S_REPORT);
  assign game.move_valid_o = (state == S_REPORT) && (|mask);
  assign game.valid_mask_o = mask;
  assign game.timeout_o    = timeout_q;
  assign game.busy_o       = !(state inside {S_IDLE, S_WAIT_MOVE});

  // RAM port mux: only the registered owner's write enable can reach the RAM.
  always_comb begin
    ram_addr = v_addr;
    ram_data = 2'd0;
    ram_wren = 1'b0;
    case (owner)
      OWN_INIT: begin
        ram_addr = i_addr;
        ram_data = i_data;
        ram_wren = i_wren;
      end
      OWN_VAL: begin
        ram_addr = v_addr;
        ram_data = v_data;
        ram_wren = v_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: validator behavioural model,
// hand-written vector table, randomized moves and reset/ownership corner cases.
module tb_move_scheduler;
  localparam int R = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       init_start_o, init_done_i;
  logic [6:0] v_addr_o;
  logic       v_player_o;
  logic [4:0] v_step_o;
  logic       v_ld_o, v_en_o, v_dir_status_i, v_done_i;
  logic [6:0] i_addr, v_addr, ram_addr;
  logic [1:0] i_data, v_data, ram_data;
  logic       i_wren, v_wren, ram_wren;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  move_scheduler_if gif();

  move_scheduler dut (
    .clock(clock), .reset(reset), .game(gif),
    .init_start_o(init_start_o), .init_done_i(init_done_i),
    .v_addr_o(v_addr_o), .v_player_o(v_player_o), .v_step_o(v_step_o),
    .v_ld_o(v_ld_o), .v_en_o(v_en_o),
    .v_dir_status_i(v_dir_status_i), .v_done_i(v_done_i),
    .i_addr(i_addr), .i_data(i_data), .i_wren(i_wren),
    .v_addr(v_addr), .v_data(v_data), .v_wren(v_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Direction steps as the game defines them, 5-bit two's complement.
  function automatic logic [4:0] step_ref(input int d);
    int s [8] = '{1, -1, R, -R, R + 1, -R - 1, R - 1, -R + 1};
    return 5'(s[d]);
  endfunction

  function automatic int dir_of(input logic [4:0] st);
    for (int d = 0; d < 8; d++) if (step_ref(d) == st) return d;
    return -1;
  endfunction

  // Validator model: done after m_len enabled cycles, status from m_sel,
  // never done for direction m_hang.
  int         m_len = 0;
  int         m_hang = -1;
  logic [7:0] m_sel = '0;
  int         vcnt = 0;
  int         vdir = 0;

  always @(posedge clock) begin
    if (v_ld_o) begin
      vcnt <= 0;
      vdir <= dir_of(v_step_o);
    end else if (v_en_o) begin
      vcnt <= vcnt + 1;
    end
  end

  assign v_done_i       = v_en_o && (vdir != m_hang) && (vcnt == m_len);
  assign v_dir_status_i = v_done_i && m_sel[vdir[2:0]];

  // Reference results for one move.
  function automatic logic [7:0] ref_mask(input int addr, input logic [7:0] sel, input int hang);
    logic [7:0] m = '0;
    if (addr >= 100) return '0;
    for (int d = 0; d < 8; d++) m[d] = sel[d] && (d != hang);
    return m;
  endfunction

  function automatic int ref_lat(input int addr, input int len, input int hang);
    int t = 2;
    if (addr >= 100) return 2;
    for (int d = 0; d < 8; d++) t += (d == hang) ? (2 + 255) : (3 + len);
    return t;
  endfunction

  function automatic logic ref_timeout(input int addr, input int hang);
    return (addr < 100) && (hang >= 0) && (hang < 8);
  endfunction

  typedef struct {
    int         addr;
    logic       pl;
    int         len;
    logic [7:0] sel;
    int         hang;
    logic [7:0] exp_mask;
    logic       exp_to;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic run_move(input string tag, input int addr, input logic pl, input int len,
                          input logic [7:0] sel, input int hang, input logic [7:0] exp_mask,
                          input logic exp_to, input int exp_lat);
    int         lat = 1;
    int         lds = 0;
    int         extra_acks = 0;
    bit         got_ack = 0;
    bit         step_ok = 1, held_ok = 1, ram_ok = 1, en_ok = 1, quiet_ok = 1, pulse_ok = 1;
    bit         prev_ld = 0;
    logic       to_after_accept = 1'b1;
    int         en_cnt [8];
    logic [4:0] steps [8];
    logic [7:0] mask_ack = '0;
    logic       valid_ack = 1'b0, to_ack = 1'b0;
    for (int d = 0; d < 8; d++) begin
      en_cnt[d] = 0;
      steps[d]  = '0;
    end
    m_len = len; m_sel = sel; m_hang = hang;
    @(negedge clock);
    gif.move_addr = 7'(addr);
    gif.player    = pl;
    gif.move_req  = 1'b1;
    @(posedge clock);
    #1 gif.move_req = 1'b0;
    for (int c = 0; c < 5000 && !got_ack; c++) begin
      @(negedge clock);
      lat++;
      if (lat == 2) to_after_accept = gif.timeout_o;
      v_addr = 7'($urandom); v_data = 2'($urandom); v_wren = 1'($urandom);
      i_addr = 7'($urandom); i_data = 2'($urandom); i_wren = 1'b1;
      #1;
      if (gif.busy_o) begin
        if (ram_addr !== v_addr || ram_data !== v_data || ram_wren !== v_wren) ram_ok = 0;
      end else begin
        if (ram_wren !== 1'b0 || ram_addr !== v_addr || ram_data !== 2'd0) ram_ok = 0;
      end
      if (v_ld_o) begin
        if (prev_ld) pulse_ok = 0;
        if (lds < 8) steps[lds] = v_step_o;
        lds++;
        if (v_addr_o !== 7'(addr) || v_player_o !== pl) held_ok = 0;
      end
      prev_ld = v_ld_o;
      if (v_en_o && lds >= 1 && lds <= 8) en_cnt[lds-1]++;
      if (gif.move_ack) begin
        got_ack   = 1;
        mask_ack  = gif.valid_mask_o;
        valid_ack = gif.move_valid_o;
        to_ack    = gif.timeout_o;
      end
    end
    check({tag, " ack seen"}, 32'(got_ack), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " mask"}, 32'(mask_ack), 32'(exp_mask));
    check({tag, " move_valid"}, 32'(valid_ack), 32'(|exp_mask));
    check({tag, " timeout"}, 32'(to_ack), 32'(exp_to));
    check({tag, " timeout cleared on accept"}, 32'(to_after_accept), 32'd0);
    check({tag, " ld pulses"}, 32'(lds), (addr < 100) ? 32'd8 : 32'd0);
    check({tag, " ld single-cycle"}, 32'(pulse_ok), 32'd1);
    check({tag, " ram mux"}, 32'(ram_ok), 32'd1);
    if (addr < 100) begin
      for (int d = 0; d < 8; d++) begin
        if (steps[d] !== step_ref(d)) step_ok = 0;
        if (en_cnt[d] != ((d == hang) ? 255 : len + 1)) en_ok = 0;
      end
      check({tag, " step sequence"}, 32'(step_ok), 32'd1);
      check({tag, " pass lengths"}, 32'(en_ok), 32'd1);
      check({tag, " addr/player held"}, 32'(held_ok), 32'd1);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (gif.move_ack) extra_acks++;
      if (gif.valid_mask_o !== exp_mask || gif.timeout_o !== exp_to || gif.busy_o !== 1'b0)
        quiet_ok = 0;
    end
    check({tag, " single ack"}, 32'(extra_acks), 32'd0);
    check({tag, " results held after ack"}, 32'(quiet_ok), 32'd1);
  endtask

  initial begin
    int  init_hi;
    bit  init_ram_ok;
    bit  hit;
    int  lds;
    int  en5;
    int  acks;
    bit  no_wren;

    // Hand-computed vectors: {addr, player, len, sel, hang, mask, timeout, latency}.
    vecs[0] = '{35,  1'b0, 5, 8'b0001_0100, -1, 8'h14, 1'b0, 66};
    vecs[1] = '{120, 1'b1, 5, 8'hFF,        -1, 8'h00, 1'b0, 2};
    vecs[2] = '{99,  1'b1, 0, 8'hFF,        -1, 8'hFF, 1'b0, 26};
    vecs[3] = '{100, 1'b0, 2, 8'hFF,        -1, 8'h00, 1'b0, 2};
    vecs[4] = '{0,   1'b1, 1, 8'b1000_0001, -1, 8'h81, 1'b0, 34};
    vecs[5] = '{35,  1'b0, 3, 8'hFF,         3, 8'hF7, 1'b1, 301};
    vecs[6] = '{44,  1'b1, 2, 8'b0010_0000, -1, 8'h20, 1'b0, 42};

    reset = 1'b1;
    init_done_i = 1'b0;
    gif.start_game = 1'b0; gif.move_req = 1'b0; gif.move_addr = '0; gif.player = 1'b0;
    i_addr = '0; i_data = '0; i_wren = 1'b0;
    v_addr = '0; v_data = '0; v_wren = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 32'(gif.busy_o), 32'd0);
    check("reset init_start", 32'(init_start_o), 32'd0);
    check("reset ram_wren", 32'(ram_wren), 32'd0);
    check("reset ack/valid/mask/timeout",
          32'({gif.move_ack, gif.move_valid_o, gif.valid_mask_o, gif.timeout_o}), 32'd0);
    check("reset validator controls", 32'({v_ld_o, v_en_o, v_step_o, v_addr_o, v_player_o}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Board initialisation: 100 INIT cycles with RAM following the initializer.
    gif.start_game = 1'b1;
    @(posedge clock);
    #1 gif.start_game = 1'b0;
    init_hi = 0;
    init_ram_ok = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (init_start_o) init_hi++;
      i_addr = 7'($urandom); i_data = 2'($urandom); i_wren = 1'($urandom);
      v_wren = 1'b1;
      #1;
      if (ram_addr !== i_addr || ram_data !== i_data || ram_wren !== i_wren) init_ram_ok = 0;
      if (k == 99) init_done_i = 1'b1;
    end
    @(posedge clock);
    #1 init_done_i = 1'b0;
    check("init_start cycles", 32'(init_hi), 32'd100);
    check("init ram follows initializer", 32'(init_ram_ok), 32'd1);
    check("after init init_start", 32'(init_start_o), 32'd0);
    check("after init busy", 32'(gif.busy_o), 32'd0);
    v_addr = 7'd77;
    #1;
    check("wait ram_wren blocked", 32'(ram_wren), 32'd0);
    check("wait ram_addr", 32'(ram_addr), 32'd77);

    // start_game wins over move_req in WAIT_MOVE; move_req is ignored in INIT.
    @(negedge clock);
    gif.start_game = 1'b1; gif.move_req = 1'b1; gif.move_addr = 7'd35;
    @(posedge clock);
    #1 gif.start_game = 1'b0;
    check("priority start_game", 32'(init_start_o), 32'd1);
    hit = 0;
    repeat (3) begin
      @(negedge clock);
      if (v_ld_o || gif.move_ack) hit = 1;
    end
    gif.move_req = 1'b0;
    check("move_req ignored in INIT", 32'(hit), 32'd0);
    init_done_i = 1'b1;
    @(posedge clock);
    #1 init_done_i = 1'b0;
    check("back to WAIT_MOVE", 32'(gif.busy_o), 32'd0);

    for (int i = 0; i < 7; i++)
      run_move($sformatf("vec%0d", i), vecs[i].addr, vecs[i].pl, vecs[i].len, vecs[i].sel,
               vecs[i].hang, vecs[i].exp_mask, vecs[i].exp_to, vecs[i].exp_lat);

    for (int i = 0; i < 20; i++) begin
      int         a = int'($urandom_range(0, 127));
      logic       p = 1'($urandom);
      int         l = int'($urandom_range(0, 8));
      logic [7:0] s = 8'($urandom);
      int         h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_move($sformatf("rnd%0d", i), a, p, l, s, h,
               ref_mask(a, s, h), ref_timeout(a, h), ref_lat(a, l, h));
    end

    // Reset during the RUN pass of direction 5 aborts the move without an ack.
    m_len = 4; m_sel = 8'hFF; m_hang = -1;
    @(negedge clock);
    gif.move_addr = 7'd57; gif.player = 1'b1; gif.move_req = 1'b1;
    @(posedge clock);
    #1 gif.move_req = 1'b0;
    hit = 0; lds = 0; en5 = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clock);
      if (v_ld_o) lds++;
      if (lds == 6 && v_en_o) en5++;
      if (en5 == 2) hit = 1;
    end
    check("reached RUN of dir 5", 32'(hit), 32'd1);
    v_wren = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid-run reset busy/ack", 32'({gif.busy_o, gif.move_ack, gif.move_valid_o}), 32'd0);
    check("mid-run reset mask/timeout", 32'({gif.valid_mask_o, gif.timeout_o}), 32'd0);
    check("mid-run reset validator", 32'({v_ld_o, v_en_o, v_step_o, v_addr_o, v_player_o}), 32'd0);
    check("mid-run reset ram_wren/init", 32'({ram_wren, init_start_o}), 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clock);
      if (gif.move_ack) acks++;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (gif.move_ack) acks++;
    end
    check("no ack after abort", 32'(acks), 32'd0);
    gif.start_game = 1'b1;
    @(posedge clock);
    #1 gif.start_game = 1'b0;
    check("re-enter INIT", 32'(init_start_o), 32'd1);
    no_wren = 1;
    repeat (5) begin
      @(negedge clock);
      i_wren = 1'b0; v_wren = 1'b1;
      #1 if (ram_wren !== 1'b0) no_wren = 0;
    end
    check("validator wren blocked in INIT", 32'(no_wren), 32'd1);
    init_done_i = 1'b1;
    @(posedge clock);
    #1 init_done_i = 1'b0;
    run_move("post-reset", 22, 1'b0, 2, 8'b0100_0010, -1,
             ref_mask(22, 8'b0100_0010, -1), 1'b0, ref_lat(22, 2, -1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
